rom_page_loader: RTL and testbench

- Parametrised successor to the fixed three-page boot-download address mapper in the top level.
- Accepts ioctl download bytes for one ioctl index and maps each 2^PAGE_BITS-byte page of the download to a configurable RAM page through a NUM_SLOTS slot table.
- Buffers bytes in a small FIFO and writes them to the SDRAM controller using a req/ack handshake.
- Reports per-page completion, out-of-range and overflow status, and holds busy so the top level keeps the machine in reset until every buffered byte has been committed.

---
 rtl/rom_loader_pkg.sv | 15 +
 rtl/loader_fifo.sv | 47 ++++
 rtl/rom_page_loader.sv | 107 ++++++++++
 tb/tb_rom_page_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared defaults, FIFO entry layout and FSM states for the ROM page loader
package rom_loader_pkg;
  localparam int DEF_ADDR_W = 23;
  localparam int DEF_PAGE_BITS = 14;
  localparam int DEF_NUM_SLOTS = 3;
  localparam int PAGE_W = DEF_ADDR_W - DEF_PAGE_BITS;
  localparam int SLOT_W = (DEF_NUM_SLOTS > 1) ? $clog2(DEF_NUM_SLOTS) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [7:0] data;
    logic last;
    logic [SLOT_W-1:0] slot;
  } loader_entry_t;
endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: synchronous FIFO with head and second-entry peek for back-to-back draining
module loader_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [W-1:0] next_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         many_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q, wp_d, rp_d, cnt;
  logic [AW-1:0] rn;
  logic do_push, do_pop;
  always_comb begin
    cnt = wp_q - rp_q;
    empty_o = cnt == '0;
    full_o = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    many_o = cnt[AW:1] != '0;
    do_pop = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wp_d = do_push ? wp_q + 1'b1 : wp_q;
    rp_d = do_pop ? rp_q + 1'b1 : rp_q;
    rn = rp_q[AW-1:0] + 1'b1;
    head_o = mem_q[rp_q[AW-1:0]];
    next_o = mem_q[rn];
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
endmodule

// File: rtl/rom_page_loader.sv
// rom_page_loader: maps ioctl download pages onto RAM pages through a slot table,
// buffering bytes in a FIFO ahead of a req/ack RAM write port
module rom_page_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PAGE_BITS = DEF_PAGE_BITS,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter logic [NUM_SLOTS*(ADDR_W-PAGE_BITS)-1:0] SLOT_MAP = {9'h107, 9'h100, 9'h000},
  parameter int FIFO_DEPTH = 4,
  parameter int DL_INDEX = 0
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [7:0]           ram_din,
  input  logic                 ram_ack,
  output logic                 busy,
  output logic [NUM_SLOTS-1:0] page_loaded,
  output logic                 out_of_range,
  output logic                 overflow
);
  localparam int PW = ADDR_W - PAGE_BITS;
  localparam int SIDX_W = 25 - PAGE_BITS;
  state_t state_q, state_d;
  loader_entry_t push_e, head_e, next_e, pres_q, pres_d;
  logic active, active_q, start, accept, in_range, push, pop;
  logic full, empty, many, load_head, load_next;
  logic ram_we_q, ram_we_d, oor_q, oor_d, ovf_q, ovf_d;
  logic [NUM_SLOTS-1:0] page_loaded_q, page_loaded_d;
  logic [SIDX_W-1:0] slot_idx;
  logic [PW-1:0] page_sel;
  loader_fifo #(.W($bits(loader_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_sys),
    .rst_i(reset),
    .push_i(push),
    .din_i(push_e),
    .pop_i(pop),
    .head_o(head_e),
    .next_o(next_e),
    .full_o(full),
    .empty_o(empty),
    .many_o(many)
  );
  always_comb begin
    active = ioctl_download & (ioctl_index == 8'(DL_INDEX));
    start = active & ~active_q;
    slot_idx = ioctl_addr[24:PAGE_BITS];
    in_range = slot_idx < SIDX_W'(NUM_SLOTS);
    page_sel = SLOT_MAP[slot_idx*PW +: PW];
    push_e = '{addr: {page_sel, ioctl_addr[PAGE_BITS-1:0]}, data: ioctl_dout,
               last: &ioctl_addr[PAGE_BITS-1:0], slot: slot_idx[SLOT_W-1:0]};
    accept = (state_q == LOAD) & ioctl_wr & active;
    pop = ram_we_q & ram_ack;
    // a full FIFO still takes the byte when the head retires on the same edge
    push = accept & in_range & (~full | pop);
    load_head = ~ram_we_q & ~empty;
    load_next = pop & many;
    ram_we_d = load_head | load_next | (ram_we_q & ~ram_ack);
    pres_d = load_next ? next_e : load_head ? head_e : pres_q;
    page_loaded_d = (start ? '0 : page_loaded_q) |
                    ((pop & pres_q.last) ? (NUM_SLOTS'(1) << pres_q.slot) : '0);
    oor_d = (~start & oor_q) | (accept & ~in_range);
    ovf_d = (~start & ovf_q) | (accept & in_range & full & ~pop);
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? LOAD : IDLE) :
              (state_q == LOAD) ? (active ? LOAD : DRAIN) :
              start ? LOAD : (empty & ~ram_we_q) ? IDLE : DRAIN;
  end
  always_comb begin
    busy = state_q != IDLE;
    ram_we = ram_we_q;
    ram_addr = pres_q.addr;
    ram_din = pres_q.data;
    page_loaded = page_loaded_q;
    out_of_range = oor_q;
    overflow = ovf_q;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      active_q <= 1'b0;
      ram_we_q <= 1'b0;
      pres_q <= '0;
      page_loaded_q <= '0;
      oor_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      active_q <= active;
      ram_we_q <= ram_we_d;
      pres_q <= pres_d;
      page_loaded_q <= page_loaded_d;
      oor_q <= oor_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_rom_page_loader.sv
// tb_rom_page_loader: directed checks of page mapping, backpressure, drain/restart and reset
module tb_rom_page_loader;
  import rom_loader_pkg::*;
  logic clk_sys = 1'b0;
  logic reset, ioctl_download, ioctl_wr, ram_ack, ram_we, busy, out_of_range, overflow;
  logic [7:0] ioctl_index, ioctl_dout, ram_din;
  logic [24:0] ioctl_addr;
  logic [22:0] ram_addr;
  logic [2:0] page_loaded;
  logic [30:0] wq[$];
  logic [22:0] base [3];
  int checks = 0, passed = 0, cyc = 0, last_ack_cyc = 0;
  rom_page_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_ack(ram_ack), .busy(busy), .page_loaded(page_loaded),
    .out_of_range(out_of_range), .overflow(overflow)
  );
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (!reset && ram_we && ram_ack) begin
      wq.push_back({ram_addr, ram_din});
      last_ack_cyc <= cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(negedge clk_sys);
  endtask
  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask
  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
  endtask
  task automatic stop_dl();
    ioctl_download = 1'b0;
    tick();
  endtask
  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40 && busy; k++) tick();
    chk(tag, busy, 0);
  endtask
  task automatic wait_wr(input int n);
    for (int k = 0; k < 40 && wq.size() < n; k++) tick();
    repeat (3) tick();
  endtask
  function automatic logic [7:0] nom_data(input int i);
    return 8'(i) ^ 8'(i >> 8);
  endfunction
  initial begin
    int bad, d;
    base = '{23'h000000, 23'h400000, 23'h41C000};
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ram_ack = 1'b0;
    repeat (2) tick();
    chk("rst_we", ram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pl", page_loaded, 0);
    chk("rst_oor", out_of_range, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    reset = 1'b0;
    tick();
    // nominal three-page download with continuous ack
    ram_ack = 1'b1;
    start_dl(8'd0);
    chk("nom_busy", busy, 1);
    for (int i = 0; i < 49152; i++) wr(25'(i), nom_data(i));
    stop_dl();
    for (int k = 0; k < 20 && busy; k++) tick();
    d = cyc - last_ack_cyc;
    chk("nom_busy_drop", busy, 0);
    chk("nom_drop_lat", 32'((d == 2) || (d == 3)), 1);
    chk("nom_count", wq.size(), 49152);
    bad = 0;
    for (int j = 0; j < wq.size() && j < 49152; j++)
      if (wq[j] !== {base[j >> 14] + 23'(j & 16'h3FFF), nom_data(j)}) bad++;
    chk("nom_bad", bad, 0);
    chk("nom_first", wq[0], {23'h000000, 8'h00});
    chk("nom_p1_first", wq[16384][30:8], 23'h400000);
    chk("nom_p0_last", wq[16383][30:8], 23'h003FFF);
    chk("nom_last", wq[49151][30:8], 23'h41FFFF);
    chk("nom_pl", page_loaded, 3'b111);
    chk("nom_ovf", overflow, 0);
    chk("nom_oor", out_of_range, 0);
    wq.delete();
    // slot 3 is outside the table
    start_dl(8'd0);
    chk("rng_pl_clr", page_loaded, 0);
    wr(25'h0C000, 8'h55);
    repeat (3) tick();
    chk("rng_nowr", wq.size(), 0);
    chk("rng_we", ram_we, 0);
    chk("rng_oor", out_of_range, 1);
    stop_dl();
    wait_idle("rng_idle");
    // foreign ioctl index is ignored entirely
    start_dl(8'd1);
    chk("idx_busy0", busy, 0);
    wr(25'h10, 8'h11);
    wr(25'h11, 8'h22);
    tick();
    chk("idx_busy1", busy, 0);
    chk("idx_nowr", wq.size(), 0);
    chk("idx_oor_kept", out_of_range, 1);
    stop_dl();
    // backpressure: 6 bytes into 4 entries
    ram_ack = 1'b0;
    start_dl(8'd0);
    chk("bp_oor_clr", out_of_range, 0);
    for (int i = 0; i < 6; i++) wr(25'(32'h10 + i), 8'(32'hA0 + i));
    chk("bp_we", ram_we, 1);
    chk("bp_addr0", ram_addr, 23'h10);
    chk("bp_din0", ram_din, 8'hA0);
    repeat (4) tick();
    chk("bp_addr1", ram_addr, 23'h10);
    chk("bp_din1", ram_din, 8'hA0);
    chk("bp_ovf", overflow, 1);
    ram_ack = 1'b1;
    wait_wr(4);
    chk("bp_count", wq.size(), 4);
    for (int k = 0; k < 4 && k < wq.size(); k++)
      chk("bp_order", wq[k], {23'(32'h10 + k), 8'(32'hA0 + k)});
    stop_dl();
    wait_idle("bp_idle");
    wq.delete();
    // full FIFO with push and pop on the same edge
    ram_ack = 1'b0;
    start_dl(8'd0);
    chk("full_ovf_clr", overflow, 0);
    for (int i = 0; i < 4; i++) wr(25'(32'h20 + i), 8'(32'hB0 + i));
    ioctl_addr = 25'h24; ioctl_dout = 8'hB4; ioctl_wr = 1'b1; ram_ack = 1'b1;
    tick();
    ioctl_wr = 1'b0; ram_ack = 1'b0;
    chk("full_ovf0", overflow, 0);
    chk("full_we", ram_we, 1);
    chk("full_next", {ram_addr, ram_din}, {23'h21, 8'hB1});
    wr(25'h25, 8'hB5);
    chk("full_still", overflow, 1);
    ram_ack = 1'b1;
    wait_wr(5);
    chk("full_count", wq.size(), 5);
    for (int k = 0; k < 5 && k < wq.size(); k++)
      chk("full_order", wq[k], {23'(32'h20 + k), 8'(32'hB0 + k)});
    stop_dl();
    wait_idle("full_idle");
    wq.delete();
    // drain after download drops
    ram_ack = 1'b0;
    start_dl(8'd0);
    wr(25'h30, 8'hC0);
    wr(25'h31, 8'hC1);
    wr(25'h3FFF, 8'hC2);
    stop_dl();
    chk("dr_state", dut.state_q, DRAIN);
    for (int k = 0; k < 3; k++) begin
      chk("dr_busy", busy, 1);
      ram_ack = 1'b1;
      tick();
      ram_ack = 1'b0;
      tick();
    end
    chk("dr_count", wq.size(), 3);
    chk("dr_last", wq[2], {23'h003FFF, 8'hC2});
    chk("dr_pl", page_loaded, 3'b001);
    chk("dr_we", ram_we, 0);
    wait_idle("dr_idle");
    wq.delete();
    // restart while draining
    start_dl(8'd0);
    wr(25'h40, 8'hD0);
    wr(25'h0C000, 8'hEE);
    wr(25'h7FFF, 8'hD1);
    stop_dl();
    chk("rs_drain", dut.state_q, DRAIN);
    chk("rs_oor", out_of_range, 1);
    ioctl_download = 1'b1;
    tick();
    chk("rs_state", dut.state_q, LOAD);
    chk("rs_oor_clr", out_of_range, 0);
    chk("rs_pres", {ram_we, ram_addr, ram_din}, {1'b1, 23'h40, 8'hD0});
    ram_ack = 1'b1;
    wait_wr(2);
    chk("rs_count", wq.size(), 2);
    chk("rs_w1", wq[1], {23'h403FFF, 8'hD1});
    chk("rs_pl", page_loaded, 3'b010);
    ram_ack = 1'b0;
    stop_dl();
    wait_idle("rs_idle");
    wq.delete();
    // reset with a request outstanding
    start_dl(8'd0);
    wr(25'h50, 8'hE0);
    wr(25'h0C000, 8'hEE);
    wr(25'h3FFF, 8'hE1);
    chk("mr_we", ram_we, 1);
    chk("mr_oor", out_of_range, 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    chk("mr_we0", ram_we, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_flags", {page_loaded, out_of_range, overflow}, 0);
    chk("mr_addr", ram_addr, 0);
    chk("mr_din", ram_din, 0);
    reset = 1'b0;
    ram_ack = 1'b1;
    repeat (4) tick();
    chk("mr_nowr", wq.size(), 0);
    chk("mr_pl", page_loaded, 0);
    chk("mr_we_late", ram_we, 0);
    ram_ack = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
